// File: rtl/target_scheduler_pkg.sv
// Shared types and helpers for the target-field round sequencer.
package target_scheduler_pkg;

  localparam int          IDX_W     = 4;
  localparam logic [31:0] SCORE_SAT = 32'hFFFF_FFFE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PICK,
    ST_SHOW,
    ST_GAP,
    ST_OVER
  } state_e;

  // Button activity seen during SHOW, decoded against the lit target.
  typedef struct packed {
    logic wrong;
    logic right;
  } press_t;

  // Show window for a given score: base minus score*step, floored at min_show.
  // Product kept in 64 b so a large score cannot wrap into a long window.
  function automatic logic [31:0] show_time(input logic [31:0] score,
                                            input logic [31:0] base,
                                            input logic [31:0] min_show,
                                            input logic [31:0] step);
    logic [63:0] dec;
    logic [31:0] val;
    dec = {32'd0, score} * {32'd0, step};
    if (dec >= {32'd0, base}) val = 32'd0;
    else                      val = base - dec[31:0];
    return (val < min_show) ? min_show : val;
  endfunction

endpackage

// File: rtl/target_scheduler_timer.sv
// Loadable 32-bit down-counter; done flags the last cycle of a window (count==1).
module target_scheduler_timer (
  input  logic        clock_i,
  input  logic        resetn_i,
  input  logic        load_i,
  input  logic [31:0] load_val_i,
  input  logic        en_i,
  output logic        done_o
);

  logic [31:0] cnt_q;

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i)                  cnt_q <= 32'd0;
    else if (load_i)                cnt_q <= load_val_i;
    else if (en_i && cnt_q != '0)   cnt_q <= cnt_q - 32'd1;
  end

  assign done_o = (cnt_q == 32'd1);

endmodule

// File: rtl/target_scheduler.sv
// Round sequencer: picks a target from the RNG, times the player, keeps score and misses.
module target_scheduler
  import target_scheduler_pkg::*;
#(
  parameter int unsigned NUM_TARGETS = 10,
  parameter int unsigned BASE_SHOW   = 25_000_000,
  parameter int unsigned MIN_SHOW    = 5_000_000,
  parameter int unsigned STEP        = 500_000,
  parameter int unsigned GAP_CYCLES  = 5_000_000,
  parameter int unsigned MAX_MISSES  = 3,
  parameter int unsigned MAX_RETRY   = 4
) (
  input  logic                   clock_i,
  input  logic                   resetn_i,
  input  logic                   start_i,
  input  logic [NUM_TARGETS-1:0] hit_i,
  input  logic [IDX_W-1:0]       rng_num_i,
  output logic [31:0]            rng_mod_o,
  output logic [NUM_TARGETS-1:0] target_o,
  output logic [IDX_W-1:0]       target_idx_o,
  output logic                   target_on_o,
  output logic [31:0]            score_o,
  output logic [3:0]             misses_o,
  output logic                   hit_pulse_o,
  output logic                   miss_pulse_o,
  output logic                   game_over_o
);

  localparam int               RW        = $clog2(MAX_RETRY + 2);
  localparam logic [RW-1:0]    RETRY_LIM = RW'(MAX_RETRY);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_TARGETS - 1);
  localparam logic [3:0]       MISS_LIM  = 4'(MAX_MISSES);

  state_e                 state_q;
  logic [NUM_TARGETS-1:0] hit_q, target_q;
  logic [IDX_W-1:0]       idx_q;
  logic                   on_q, hp_q, mp_q, go_q;
  logic [31:0]            score_q, rng_mod_q;
  logic [3:0]             misses_q;
  logic [RW-1:0]          retry_q;

  logic [NUM_TARGETS-1:0] edge_w, pick_oh;
  press_t                 press;
  logic                   rng_ok, retry_out, pick_take;
  logic [IDX_W-1:0]       fb_idx, pick_idx;
  logic                   hit_ev, miss_ev, last_miss;
  logic                   tmr_load, tmr_en, tmr_done;
  logic [31:0]            tmr_val;

  assign edge_w      = hit_i & ~hit_q;
  // target_q is one-hot of the lit index throughout SHOW, so it doubles as the mask
  assign press.right = |(edge_w & target_q);
  assign press.wrong = |(edge_w & ~target_q);

  assign rng_ok    = (rng_num_i <= LAST_IDX) && (rng_num_i != idx_q);
  assign retry_out = (retry_q == RETRY_LIM);
  assign fb_idx    = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
  assign pick_idx  = retry_out ? fb_idx : rng_num_i;
  assign pick_take = (state_q == ST_PICK) && (retry_out || rng_ok);
  assign pick_oh   = {{(NUM_TARGETS-1){1'b0}}, 1'b1} << pick_idx;

  // A wrong press beats a simultaneous right press; a press beats the timeout.
  assign miss_ev   = (state_q == ST_SHOW) && (press.wrong || (!press.right && tmr_done));
  assign hit_ev    = (state_q == ST_SHOW) && !press.wrong && press.right;
  assign last_miss = ((misses_q + 4'd1) == MISS_LIM);

  assign tmr_load = pick_take || hit_ev || (miss_ev && !last_miss);
  assign tmr_val  = pick_take ? show_time(score_q, BASE_SHOW, MIN_SHOW, STEP) : GAP_CYCLES;
  assign tmr_en   = (state_q == ST_SHOW) || (state_q == ST_GAP);

  target_scheduler_timer u_timer (
    .clock_i    (clock_i),
    .resetn_i   (resetn_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .done_o     (tmr_done)
  );

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q   <= ST_IDLE;
      hit_q     <= '0;
      target_q  <= '0;
      idx_q     <= '0;
      on_q      <= 1'b0;
      score_q   <= '0;
      misses_q  <= '0;
      hp_q      <= 1'b0;
      mp_q      <= 1'b0;
      go_q      <= 1'b0;
      rng_mod_q <= 32'd1;
      retry_q   <= '0;
    end else begin
      hit_q     <= hit_i;
      rng_mod_q <= score_q + 32'd1;
      hp_q      <= 1'b0;
      mp_q      <= 1'b0;
      case (state_q)
        ST_IDLE, ST_OVER: begin
          if (start_i) begin
            score_q  <= '0;
            misses_q <= '0;
            go_q     <= 1'b0;
            retry_q  <= '0;
            state_q  <= ST_PICK;
          end
        end
        ST_PICK: begin
          if (pick_take) begin
            idx_q    <= pick_idx;
            target_q <= pick_oh;
            on_q     <= 1'b1;
            retry_q  <= '0;
            state_q  <= ST_SHOW;
          end else begin
            retry_q  <= retry_q + 1'b1;
          end
        end
        ST_SHOW: begin
          if (miss_ev) begin
            mp_q     <= 1'b1;
            misses_q <= misses_q + 4'd1;
            target_q <= '0;
            on_q     <= 1'b0;
            go_q     <= last_miss;
            state_q  <= last_miss ? ST_OVER : ST_GAP;
          end else if (hit_ev) begin
            hp_q     <= 1'b1;
            score_q  <= (score_q == SCORE_SAT) ? score_q : score_q + 32'd1;
            target_q <= '0;
            on_q     <= 1'b0;
            state_q  <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (tmr_done) begin
            retry_q <= '0;
            state_q <= ST_PICK;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rng_mod_o    = rng_mod_q;
  assign target_o     = target_q;
  assign target_idx_o = idx_q;
  assign target_on_o  = on_q;
  assign score_o      = score_q;
  assign misses_o     = misses_q;
  assign hit_pulse_o  = hp_q;
  assign miss_pulse_o = mp_q;
  assign game_over_o  = go_q;

endmodule

// File: tb/tb_target_scheduler.sv
// Scenario bench for target_scheduler with a round-level scoring model.
module tb_target_scheduler;

  localparam int NT = 10, BASE = 20, MINS = 8, STP = 4, GAP = 3, MAXM = 3, MAXR = 4;

  logic          clock_i = 1'b0, resetn_i = 1'b1, start_i = 1'b0;
  logic [NT-1:0] hit_i = '0;
  logic [3:0]    rng_num_i = '0;
  logic [31:0]   rng_mod_o, score_o;
  logic [NT-1:0] target_o;
  logic [3:0]    target_idx_o, misses_o;
  logic          target_on_o, hit_pulse_o, miss_pulse_o, game_over_o;

  int n_cmp = 0, n_bad = 0;
  int m_score, m_misses, m_idx, base_lat;

  always #5 clock_i = ~clock_i;

  target_scheduler #(
    .NUM_TARGETS(NT), .BASE_SHOW(BASE), .MIN_SHOW(MINS), .STEP(STP),
    .GAP_CYCLES(GAP), .MAX_MISSES(MAXM), .MAX_RETRY(MAXR)
  ) dut (
    .clock_i(clock_i), .resetn_i(resetn_i), .start_i(start_i), .hit_i(hit_i),
    .rng_num_i(rng_num_i), .rng_mod_o(rng_mod_o), .target_o(target_o),
    .target_idx_o(target_idx_o), .target_on_o(target_on_o), .score_o(score_o),
    .misses_o(misses_o), .hit_pulse_o(hit_pulse_o), .miss_pulse_o(miss_pulse_o),
    .game_over_o(game_over_o)
  );

  task automatic tick;
    @(posedge clock_i); #1;
  endtask

  function automatic int exp_window(input int score);
    int w;
    w = BASE - score * STP;
    return (w < MINS) ? MINS : w;
  endfunction

  function automatic int exp_pick(input int r, input int last);
    return (r < NT && r != last) ? r : (last + 1) % NT;
  endfunction

  function automatic int exp_lat(input int r, input int last, input int base);
    return (r < NT && r != last) ? base : base + MAXR;
  endfunction

  function automatic logic [NT-1:0] onehot(input int i);
    logic [NT-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic wait_target(output int lat);
    lat = 0;
    while (!target_on_o && lat < 200) begin tick; lat++; end
  endtask

  task automatic wait_outcome(output int n);
    n = 0;
    do begin tick; n++; end while (!hit_pulse_o && !miss_pulse_o && n < 200);
  endtask

  task automatic start_game;
    start_i = 1'b1; tick; start_i = 1'b0;
  endtask

  task automatic test_reset;
    resetn_i = 1'b1; #3 resetn_i = 1'b0;
    tick; tick;
    n_cmp++; if (target_o !== '0)      begin n_bad++; $display("FAIL rst_target got %0h want 0", target_o); end
    n_cmp++; if (target_on_o !== 1'b0) begin n_bad++; $display("FAIL rst_target_on got %0b want 0", target_on_o); end
    n_cmp++; if (target_idx_o !== 4'd0) begin n_bad++; $display("FAIL rst_idx got %0d want 0", target_idx_o); end
    n_cmp++; if (score_o !== 32'd0)    begin n_bad++; $display("FAIL rst_score got %0d want 0", score_o); end
    n_cmp++; if (misses_o !== 4'd0)    begin n_bad++; $display("FAIL rst_misses got %0d want 0", misses_o); end
    n_cmp++; if ({hit_pulse_o, miss_pulse_o} !== 2'b00) begin n_bad++; $display("FAIL rst_pulses got %b want 00", {hit_pulse_o, miss_pulse_o}); end
    n_cmp++; if (game_over_o !== 1'b0) begin n_bad++; $display("FAIL rst_game_over got %0b want 0", game_over_o); end
    n_cmp++; if (rng_mod_o !== 32'd1)  begin n_bad++; $display("FAIL rst_rng_mod got %0d want 1", rng_mod_o); end
    resetn_i = 1'b1;
    tick; tick;
    n_cmp++; if (target_on_o !== 1'b0) begin n_bad++; $display("FAIL idle_target_on got %0b want 0", target_on_o); end
  endtask

  task automatic test_timeout;
    int lat, n;
    rng_num_i = 4'd2;
    start_game;
    wait_target(lat);
    n_cmp++; if (lat !== 1)                begin n_bad++; $display("FAIL to_latency got %0d want 1", lat); end
    n_cmp++; if (target_idx_o !== 4'd2)    begin n_bad++; $display("FAIL to_idx got %0d want 2", target_idx_o); end
    wait_outcome(n);
    n_cmp++; if (n !== exp_window(0))      begin n_bad++; $display("FAIL to_window got %0d want %0d", n, exp_window(0)); end
    n_cmp++; if (miss_pulse_o !== 1'b1)    begin n_bad++; $display("FAIL to_miss_pulse got %0b want 1", miss_pulse_o); end
    n_cmp++; if (misses_o !== 4'd1)        begin n_bad++; $display("FAIL to_misses got %0d want 1", misses_o); end
    n_cmp++; if (target_o !== '0)          begin n_bad++; $display("FAIL to_target_clr got %0h want 0", target_o); end
  endtask

  task automatic test_hit;
    int lat;
    rng_num_i = 4'd5;
    wait_target(lat);
    n_cmp++; if (lat !== GAP + 1)              begin n_bad++; $display("FAIL hit_latency got %0d want %0d", lat, GAP + 1); end
    n_cmp++; if (target_o !== 10'b0000100000)  begin n_bad++; $display("FAIL hit_target got %b want 0000100000", target_o); end
    tick; tick; tick;
    hit_i = onehot(5); tick;
    n_cmp++; if (hit_pulse_o !== 1'b1)         begin n_bad++; $display("FAIL hit_pulse got %0b want 1", hit_pulse_o); end
    n_cmp++; if (score_o !== 32'd1)            begin n_bad++; $display("FAIL hit_score got %0d want 1", score_o); end
    n_cmp++; if (target_o !== '0)              begin n_bad++; $display("FAIL hit_target_clr got %0h want 0", target_o); end
    n_cmp++; if (rng_mod_o !== 32'd1)          begin n_bad++; $display("FAIL hit_rng_mod_early got %0d want 1", rng_mod_o); end
    tick; hit_i = '0;
    n_cmp++; if (rng_mod_o !== 32'd2)          begin n_bad++; $display("FAIL hit_rng_mod got %0d want 2", rng_mod_o); end
    n_cmp++; if (hit_pulse_o !== 1'b0)         begin n_bad++; $display("FAIL hit_pulse_width got %0b want 0", hit_pulse_o); end
  endtask

  task automatic test_retry;
    int lat, n;
    rng_num_i = 4'd5;
    wait_target(lat);
    n_cmp++; if (lat !== GAP + MAXR)      begin n_bad++; $display("FAIL retry_same_lat got %0d want %0d", lat, GAP + MAXR); end
    n_cmp++; if (target_idx_o !== 4'd6)   begin n_bad++; $display("FAIL retry_same_idx got %0d want 6", target_idx_o); end
    wait_outcome(n);
    n_cmp++; if (n !== exp_window(1))     begin n_bad++; $display("FAIL shrink_score1 got %0d want %0d", n, exp_window(1)); end
    rng_num_i = 4'd12;
    wait_target(lat);
    n_cmp++; if (lat !== GAP + 1 + MAXR)  begin n_bad++; $display("FAIL retry_big_lat got %0d want %0d", lat, GAP + 1 + MAXR); end
    n_cmp++; if (target_idx_o !== 4'd7)   begin n_bad++; $display("FAIL retry_big_idx got %0d want 7", target_idx_o); end
    hit_i = onehot(7); tick; hit_i = '0;
    rng_num_i = 4'd9;
    wait_target(lat);
    tick; hit_i = onehot(9); tick; hit_i = '0;
    n_cmp++; if (score_o !== 32'd3)       begin n_bad++; $display("FAIL retry_score got %0d want 3", score_o); end
    rng_num_i = 4'd12;
    wait_target(lat);
    n_cmp++; if (target_idx_o !== 4'd0)   begin n_bad++; $display("FAIL retry_wrap_idx got %0d want 0", target_idx_o); end
    wait_outcome(n);
    n_cmp++; if (n !== exp_window(3))     begin n_bad++; $display("FAIL shrink_score3 got %0d want %0d", n, exp_window(3)); end
    n_cmp++; if (game_over_o !== 1'b1)    begin n_bad++; $display("FAIL over_by_misses got %0b want 1", game_over_o); end
  endtask

  task automatic test_game_over;
    int lat, n;
    hit_i = onehot(3); tick; hit_i = '0; tick; tick;
    n_cmp++; if (score_o !== 32'd3)      begin n_bad++; $display("FAIL over_score_held got %0d want 3", score_o); end
    n_cmp++; if (misses_o !== 4'd3)      begin n_bad++; $display("FAIL over_misses_held got %0d want 3", misses_o); end
    start_game;
    n_cmp++; if (score_o !== 32'd0)      begin n_bad++; $display("FAIL restart_score got %0d want 0", score_o); end
    n_cmp++; if (game_over_o !== 1'b0)   begin n_bad++; $display("FAIL restart_game_over got %0b want 0", game_over_o); end
    for (int r = 1; r <= 3; r++) begin
      rng_num_i = 4'(r);
      wait_target(lat);
      tick; hit_i = onehot(r) | onehot((r + 1) % NT); tick; hit_i = '0;
      n_cmp++; if (miss_pulse_o !== 1'b1) begin n_bad++; $display("FAIL both_edges_miss r%0d got %0b want 1", r, miss_pulse_o); end
    end
    n_cmp++; if (game_over_o !== 1'b1)   begin n_bad++; $display("FAIL over_by_both got %0b want 1", game_over_o); end
    n_cmp++; if (score_o !== 32'd0)      begin n_bad++; $display("FAIL over_by_both_score got %0d want 0", score_o); end
  endtask

  task automatic test_random;
    int lat, n, r, act, d, used, win, want_idx;
    m_idx = 3; m_score = 0; m_misses = 0; base_lat = 1;
    start_game;
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 15);
      rng_num_i = 4'(r);
      want_idx = exp_pick(r, m_idx);
      wait_target(lat);
      n_cmp++; if (lat !== exp_lat(r, m_idx, base_lat)) begin n_bad++; $display("FAIL rnd%0d_lat got %0d want %0d", k, lat, exp_lat(r, m_idx, base_lat)); end
      n_cmp++; if (target_o !== onehot(want_idx)) begin n_bad++; $display("FAIL rnd%0d_target got %b want %b", k, target_o, onehot(want_idx)); end
      n_cmp++; if (rng_mod_o !== 32'(m_score + 1)) begin n_bad++; $display("FAIL rnd%0d_rng_mod got %0d want %0d", k, rng_mod_o, m_score + 1); end
      m_idx = want_idx;
      win = exp_window(m_score);
      used = 0;
      if ($urandom_range(0, 2) == 0) begin start_i = 1'b1; tick; start_i = 1'b0; used = 1; end
      act = $urandom_range(0, 3);
      if (act == 0) begin
        wait_outcome(n);
        n_cmp++; if (n + used !== win) begin n_bad++; $display("FAIL rnd%0d_window got %0d want %0d", k, n + used, win); end
      end else begin
        d = $urandom_range(used, win - 1);
        for (int j = used; j < d; j++) tick;
        hit_i = '0;
        if (act != 2) hit_i = hit_i | onehot(m_idx);
        if (act != 1) hit_i = hit_i | onehot((m_idx + 1 + $urandom_range(0, NT - 2)) % NT);
        tick; hit_i = '0;
      end
      if (act == 1) m_score++; else m_misses++;
      n_cmp++; if ({hit_pulse_o, miss_pulse_o} !== ((act == 1) ? 2'b10 : 2'b01)) begin n_bad++; $display("FAIL rnd%0d_pulses got %b act %0d", k, {hit_pulse_o, miss_pulse_o}, act); end
      n_cmp++; if (score_o !== 32'(m_score)) begin n_bad++; $display("FAIL rnd%0d_score got %0d want %0d", k, score_o, m_score); end
      n_cmp++; if (misses_o !== 4'(m_misses)) begin n_bad++; $display("FAIL rnd%0d_misses got %0d want %0d", k, misses_o, m_misses); end
      n_cmp++; if (game_over_o !== (m_misses == MAXM)) begin n_bad++; $display("FAIL rnd%0d_game_over got %0b want %0b", k, game_over_o, m_misses == MAXM); end
      if (m_misses == MAXM) begin
        tick; start_game;
        m_score = 0; m_misses = 0; base_lat = 1;
      end else begin
        base_lat = GAP + 1;
      end
    end
  endtask

  task automatic test_reset_mid_show;
    int lat;
    rng_num_i = 4'((m_idx + 1) % NT);
    wait_target(lat);
    n_cmp++; if (target_on_o !== 1'b1)  begin n_bad++; $display("FAIL mid_show_on got %0b want 1", target_on_o); end
    #2 resetn_i = 1'b0;
    #1;
    n_cmp++; if ({target_o, target_on_o, target_idx_o} !== '0) begin n_bad++; $display("FAIL mid_rst_target got %0h/%0b/%0d want 0", target_o, target_on_o, target_idx_o); end
    n_cmp++; if ({score_o, misses_o} !== '0) begin n_bad++; $display("FAIL mid_rst_counts got %0d/%0d want 0", score_o, misses_o); end
    n_cmp++; if ({hit_pulse_o, miss_pulse_o, game_over_o} !== 3'b000) begin n_bad++; $display("FAIL mid_rst_flags got %b want 000", {hit_pulse_o, miss_pulse_o, game_over_o}); end
    n_cmp++; if (rng_mod_o !== 32'd1)   begin n_bad++; $display("FAIL mid_rst_rng_mod got %0d want 1", rng_mod_o); end
    tick; resetn_i = 1'b1; tick; tick; tick;
    n_cmp++; if (target_on_o !== 1'b0)  begin n_bad++; $display("FAIL post_rst_idle got %0b want 0", target_on_o); end
    rng_num_i = 4'd4;
    start_game;
    wait_target(lat);
    n_cmp++; if (lat !== 1 || target_idx_o !== 4'd4) begin n_bad++; $display("FAIL post_rst_start got lat %0d idx %0d want 1/4", lat, target_idx_o); end
  endtask

  initial begin
    test_reset;
    test_timeout;
    test_hit;
    test_retry;
    test_game_over;
    test_random;
    test_reset_mid_show;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400_000;
    $display("FAIL watchdog expired after %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
